// File: rtl/div_arbiter.sv
// Round-robin arbiter and sequencer that shares one iterative signed divider between two clients.
// Drives the divider's restart/ready handshake and returns quotient, overflow or timeout to the owner.
module div_arbiter #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] dividend0,
    input  logic [31:0] dividend1,
    input  logic [31:0] divisor0,
    input  logic [31:0] divisor1,
    output logic        grant0,
    output logic        grant1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        overflow,
    output logic        err,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_reset,
    input  logic [31:0] div_result,
    input  logic        div_overflow,
    input  logic        div_ready
);

    localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant0_q, grant0_d;
    logic          grant1_q, grant1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [31:0]   result_q, result_d;
    logic          overflow_q, overflow_d;
    logic          err_q, err_d;
    logic [31:0]   dvd_q, dvd_d;
    logic [31:0]   dvs_q, dvs_d;

    logic          sel_s;
    logic [CW-1:0] cnt_inc_s;

    // On a tie the requester not served last wins; otherwise the lone requester wins.
    assign sel_s     = (req0 & req1) ? ~last_q : req1;
    assign cnt_inc_s = cnt_q + CW'(1);

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant0_d   = grant0_q;
        grant1_d   = grant1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d  = sel_s;
                    grant0_d = ~sel_s;
                    grant1_d = sel_s;
                    dvd_d    = sel_s ? dividend1 : dividend0;
                    dvs_d    = sel_s ? divisor1  : divisor0;
                    state_d  = LOAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOAD: begin
                // Overflow is decided from the operands alone, so the divider is never run.
                if (div_overflow) begin
                    result_d   = 32'd0;
                    overflow_d = 1'b1;
                    err_d      = 1'b0;
                    done0_d    = ~owner_q;
                    done1_d    = owner_q;
                    state_d    = DONE;
                end else begin
                    cnt_d      = {CW{1'b0}};
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (div_ready) begin
                    result_d   = div_result;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                    done0_d    = ~owner_q;
                    done1_d    = owner_q;
                    state_d    = DONE;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    result_d   = 32'd0;
                    overflow_d = 1'b1;
                    err_d      = 1'b1;
                    done0_d    = ~owner_q;
                    done1_d    = owner_q;
                    state_d    = DONE;
                end else begin
                    cnt_d      = cnt_inc_s;
                end
            end
            DONE: begin
                last_d   = owner_q;
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= {CW{1'b0}};
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
        end
    end

    // Divider restart is held while in reset so it never runs on stale operands.
    assign div_reset    = ~reset | (state_q == LOAD);
    assign grant0       = grant0_q;
    assign grant1       = grant1_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign err          = err_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural 32-cycle divider that can be stalled.
module tb_div_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] dividend0 = 32'd0, dividend1 = 32'd0;
    logic [31:0] divisor0 = 32'd0, divisor1 = 32'd0;
    logic        grant0, grant1, done0, done1, overflow, err, div_reset;
    logic [31:0] result, div_dividend, div_divisor, div_result;
    logic        div_overflow, div_ready;
    logic        stuck = 1'b0;
    logic [5:0]  mcnt;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    div_arbiter #(.TIMEOUT(40)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1),
        .dividend0(dividend0), .dividend1(dividend1),
        .divisor0(divisor0), .divisor1(divisor1),
        .grant0(grant0), .grant1(grant1),
        .done0(done0), .done1(done1),
        .result(result), .overflow(overflow), .err(err),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_reset(div_reset),
        .div_result(div_result), .div_overflow(div_overflow), .div_ready(div_ready)
    );

    // Divider model: ready in its 32nd cycle after restart.
    always @(posedge clock) begin
        if (div_reset) mcnt <= 6'd0;
        else if (mcnt != 6'd63) mcnt <= mcnt + 6'd1;
    end
    assign div_ready    = !stuck && (mcnt == 6'd31);
    assign div_overflow = (div_divisor == 32'd0) ||
                          (div_dividend == 32'h80000000 && div_divisor == 32'hFFFFFFFF);
    always_comb begin
        div_result = 32'd0;
        if (!div_overflow) div_result = $signed(div_dividend) / $signed(div_divisor);
    end

    task automatic wait_done(output int lat, output int drst);
        lat = -1;
        drst = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock); #1;
            if (div_reset) drst++;
            if (done0 || done1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if ({grant0, grant1, done0, done1} !== 4'b0000) begin n_fail++; $display("FAIL reset_gd: got %b want 0000", {grant0, grant1, done0, done1}); end
        n_cmp++; if ({result, overflow, err} !== 34'd0) begin n_fail++; $display("FAIL reset_res: got %h/%b/%b want 0/0/0", result, overflow, err); end
        n_cmp++; if ({div_dividend, div_divisor} !== 64'd0) begin n_fail++; $display("FAIL reset_ops: got %h/%h want 0/0", div_dividend, div_divisor); end
        n_cmp++; if (div_reset !== 1'b1) begin n_fail++; $display("FAIL reset_divrst: got %b want 1", div_reset); end
        @(negedge clock); reset = 1'b1; #1;
        n_cmp++; if (div_reset !== 1'b0) begin n_fail++; $display("FAIL idle_divrst: got %b want 0", div_reset); end
    endtask

    task automatic test_basic;
        int lat, drst;
        @(negedge clock); dividend0 = 32'd100; divisor0 = 32'd7; req0 = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if ({grant0, grant1, div_reset} !== 3'b101) begin n_fail++; $display("FAIL basic_grant: got %b want 101", {grant0, grant1, div_reset}); end
        n_cmp++; if ({div_dividend, div_divisor} !== {32'd100, 32'd7}) begin n_fail++; $display("FAIL basic_ops: got %h/%h want 64/7", div_dividend, div_divisor); end
        dividend0 = 32'd5;
        wait_done(lat, drst);
        n_cmp++; if (lat + 1 !== 34) begin n_fail++; $display("FAIL basic_lat: got %0d want 34", lat + 1); end
        n_cmp++; if ({done0, done1} !== 2'b10) begin n_fail++; $display("FAIL basic_done: got %b want 10", {done0, done1}); end
        n_cmp++; if ({result, overflow, err} !== {32'd14, 2'b00}) begin n_fail++; $display("FAIL basic_res: got %h/%b/%b want e/0/0", result, overflow, err); end
        req0 = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if ({done0, grant0, result} !== {2'b00, 32'd14}) begin n_fail++; $display("FAIL basic_after: got %b/%b/%h want 0/0/e", done0, grant0, result); end
    endtask

    task automatic test_req1;
        int lat, drst;
        @(negedge clock); dividend1 = 32'hFFFFFF9C; divisor1 = 32'd7; req1 = 1'b1;
        wait_done(lat, drst);
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL neg_lat: got %0d want 34", lat); end
        n_cmp++; if ({done0, done1, result} !== {2'b01, 32'hFFFFFFF2}) begin n_fail++; $display("FAIL neg_res: got %b%b/%h want 01/fffffff2", done0, done1, result); end
        req1 = 1'b0;
        @(posedge clock); #1;
        @(negedge clock); dividend1 = 32'h80000000; divisor1 = 32'hFFFFFFFF; req1 = 1'b1;
        wait_done(lat, drst);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL minneg_lat: got %0d want 2", lat); end
        n_cmp++; if ({done1, result, overflow, err} !== {1'b1, 32'd0, 2'b10}) begin n_fail++; $display("FAIL minneg_res: got %b/%h/%b/%b want 1/0/1/0", done1, result, overflow, err); end
        req1 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int lat, drst;
        @(negedge clock);
        dividend0 = 32'd1000; divisor0 = 32'd10;
        dividend1 = 32'hFFFFFFAF; divisor1 = 32'd9;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(lat, drst);
            n_cmp++; if (lat !== ((k == 0) ? 34 : 35)) begin n_fail++; $display("FAIL b2b_lat%0d: got %0d want %0d", k, lat, (k == 0) ? 34 : 35); end
            n_cmp++; if ({done0, done1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_owner%0d: got %b%b", k, done0, done1); end
            n_cmp++; if (result !== ((k % 2 == 0) ? 32'd100 : 32'hFFFFFFF7)) begin n_fail++; $display("FAIL b2b_res%0d: got %h", k, result); end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if ({done0, done1, grant0, grant1} !== 4'b0000) begin n_fail++; $display("FAIL b2b_end: got %b want 0000", {done0, done1, grant0, grant1}); end
    endtask

    task automatic test_fast_path;
        int lat, drst;
        @(negedge clock); dividend0 = 32'd55; divisor0 = 32'd0; req0 = 1'b1;
        wait_done(lat, drst);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL div0_lat: got %0d want 2", lat); end
        n_cmp++; if (drst !== 1) begin n_fail++; $display("FAIL div0_divrst: got %0d cycles want 1", drst); end
        n_cmp++; if ({done0, result, overflow, err} !== {1'b1, 32'd0, 2'b10}) begin n_fail++; $display("FAIL div0_res: got %b/%h/%b/%b want 1/0/1/0", done0, result, overflow, err); end
        req0 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_timeout;
        int lat, drst;
        stuck = 1'b1;
        @(negedge clock); dividend1 = 32'd12; divisor1 = 32'd3; req1 = 1'b1;
        wait_done(lat, drst);
        n_cmp++; if (lat !== 42) begin n_fail++; $display("FAIL tmo_lat: got %0d want 42", lat); end
        n_cmp++; if ({done1, result, overflow, err} !== {1'b1, 32'd0, 2'b11}) begin n_fail++; $display("FAIL tmo_res: got %b/%h/%b/%b want 1/0/1/1", done1, result, overflow, err); end
        req1 = 1'b0; stuck = 1'b0;
        @(posedge clock); #1;
        @(negedge clock); dividend0 = 32'd12; divisor0 = 32'd3; req0 = 1'b1;
        wait_done(lat, drst);
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL post_tmo_lat: got %0d want 34", lat); end
        n_cmp++; if ({done0, result, overflow, err} !== {1'b1, 32'd4, 2'b00}) begin n_fail++; $display("FAIL post_tmo_res: got %b/%h/%b/%b want 1/4/0/0", done0, result, overflow, err); end
        req0 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midrun;
        int lat, drst, ndone;
        @(negedge clock); dividend0 = 32'd100; divisor0 = 32'd7; req0 = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock); reset = 1'b0; req0 = 1'b0; #1;
        n_cmp++; if (div_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_divrst: got %b want 1", div_reset); end
        @(posedge clock); #1;
        n_cmp++; if ({grant0, grant1, done0, done1, result} !== 36'd0) begin n_fail++; $display("FAIL midrst_out: got %b/%h want 0000/0", {grant0, grant1, done0, done1}, result); end
        @(negedge clock); reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done0 || done1 || grant0 || grant1) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles want 0", ndone); end
        @(negedge clock);
        dividend0 = 32'd21; divisor0 = 32'd7; dividend1 = 32'd9; divisor1 = 32'd3;
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if ({grant0, grant1} !== 2'b10) begin n_fail++; $display("FAIL midrst_tie: got %b want 10", {grant0, grant1}); end
        req1 = 1'b0;
        wait_done(lat, drst);
        n_cmp++; if ({done0, result} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL midrst_op: got %b/%h want 1/3", done0, result); end
        req0 = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req1();
        test_back_to_back();
        test_fast_path();
        test_timeout();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
